// File: rtl/mem_arbiter_flattened.sv
// mem_arbiter_flattened: round-robin share of one flat data-memory port
// among num_ports_p flat core ports, with one transaction in flight.
//
// Ports:
//   clk, reset        clock (posedge) and async active-high reset
//   req_flat_i        per-port requests, port k at [k*req_width_p +: req_width_p]
//   req_valid_i       per-port request pending
//   req_ready_o       one-hot accept strobe (IDLE only)
//   rsp_flat_o        registered response data, shared by all ports
//   rsp_valid_o       one-hot 1-cycle response strobe to the owning port
//   mem_req_flat_o    latched request toward memory
//   mem_req_valid_o   memory request valid
//   mem_req_ready_i   memory accepts request
//   mem_rsp_flat_i    memory response data
//   mem_rsp_valid_i   memory response strobe
//   grant_id_o        index of port owning the current transaction
//   busy_o            transaction in progress
//   protocol_err_o    sticky: memory response seen outside WAIT
module mem_arbiter_flattened #(
  parameter int num_ports_p = 4,
  parameter int req_width_p = 64,
  parameter int rsp_width_p = 32,
  parameter int id_width_p =
    (num_ports_p > 1) ? $clog2(num_ports_p) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [num_ports_p*req_width_p-1:0] req_flat_i,
  input  logic [num_ports_p-1:0]             req_valid_i,
  output logic [num_ports_p-1:0]             req_ready_o,
  output logic [rsp_width_p-1:0]             rsp_flat_o,
  output logic [num_ports_p-1:0]             rsp_valid_o,
  output logic [req_width_p-1:0]             mem_req_flat_o,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  input  logic [rsp_width_p-1:0]             mem_rsp_flat_i,
  input  logic                               mem_rsp_valid_i,
  output logic [id_width_p-1:0]              grant_id_o,
  output logic                               busy_o,
  output logic                               protocol_err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // Port 0 must win the first arbitration after reset.
  localparam logic [id_width_p-1:0] LAST_RST =
    id_width_p'(num_ports_p - 1);

  logic [1:0]             state_q, state_d;
  logic [id_width_p-1:0]  last_grant_q, last_grant_d;
  logic [id_width_p-1:0]  grant_q, grant_d;
  logic [req_width_p-1:0] req_q, req_d;
  logic [rsp_width_p-1:0] rsp_q, rsp_d;
  logic [num_ports_p-1:0] rsp_valid_q, rsp_valid_d;
  logic                   err_q, err_d;

  logic                   pick_found;
  logic [id_width_p-1:0]  pick_id;
  int                     arb_idx;

  // Rotating priority: search last_grant+1, +2, ... wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    arb_idx    = 0;
    for (int i = 1; i <= num_ports_p; i++) begin
      arb_idx = (int'(last_grant_q) + i) % num_ports_p;
      if (!pick_found && req_valid_i[arb_idx]) begin
        pick_found = 1'b1;
        pick_id    = id_width_p'(arb_idx);
      end
    end
  end

  // Gated by reset so the accept strobe is quiet while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && pick_found && !reset) begin
      req_ready_o[pick_id] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_d        = req_q;
    rsp_d        = rsp_q;
    rsp_valid_d  = '0;
    err_d        = err_q;
    if (mem_rsp_valid_i && state_q != WAIT) begin
      err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          req_d   = req_flat_i[int'(pick_id)*req_width_p +: req_width_p];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          rsp_d                = mem_rsp_flat_i;
          rsp_valid_d[grant_q] = 1'b1;
          last_grant_d         = grant_q;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      grant_q      <= '0;
      req_q        <= '0;
      rsp_q        <= '0;
      rsp_valid_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      req_q        <= req_d;
      rsp_q        <= rsp_d;
      rsp_valid_q  <= rsp_valid_d;
      err_q        <= err_d;
    end
  end

  assign rsp_flat_o      = rsp_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign mem_req_flat_o  = req_q;
  assign mem_req_valid_o = (state_q == ISSUE);
  assign grant_id_o      = grant_q;
  assign busy_o          = (state_q != IDLE);
  assign protocol_err_o  = err_q;

endmodule

// File: tb/tb_mem_arbiter_flattened.sv
// tb_mem_arbiter_flattened: directed scoreboard bench for the
// round-robin flat memory arbiter.
module tb_mem_arbiter_flattened;
  localparam int NP = 4;
  localparam int RW = 64;
  localparam int SW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP*RW-1:0] req_flat;
  logic [NP-1:0] req_valid;
  logic [NP-1:0] req_ready;
  logic [SW-1:0] rsp_flat;
  logic [NP-1:0] rsp_valid;
  logic [RW-1:0] mem_req_flat;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [SW-1:0] mem_rsp_flat;
  logic          mem_rsp_valid;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          perr;

  always #5 clk = ~clk;

  mem_arbiter_flattened #(
    .num_ports_p(NP), .req_width_p(RW),
    .rsp_width_p(SW), .id_width_p(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_flat_i(req_flat), .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .rsp_flat_o(rsp_flat), .rsp_valid_o(rsp_valid),
    .mem_req_flat_o(mem_req_flat),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_rsp_flat_i(mem_rsp_flat),
    .mem_rsp_valid_i(mem_rsp_valid),
    .grant_id_o(grant_id), .busy_o(busy),
    .protocol_err_o(perr)
  );

  typedef struct {
    int            port;
    logic [RW-1:0] req;
    logic [SW-1:0] rsp;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [SW-1:0] last_rsp;

  function automatic logic [NP-1:0] onehot(int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [SW-1:0] rsp_of(logic [RW-1:0] r);
    return r[SW-1:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int p, input logic [RW-1:0] d,
                      input logic [SW-1:0] r);
    exp_t e;
    e.port = p;
    e.req  = d;
    e.rsp  = r;
    sb.push_back(e);
  endtask

  task automatic set_req(input int p, input logic [RW-1:0] d);
    req_flat[p*RW +: RW] = d;
    req_valid[p] = 1'b1;
  endtask

  task automatic check_idle_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_flat", rsp_flat, 0);
    chk("rst_mreq_valid", mem_req_valid, 0);
    chk("rst_mreq_flat", mem_req_flat, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", perr, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_idle_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One full transaction for the head of the scoreboard; called at
  // a negedge with the requesting ports already driven.
  task automatic run_one(input int stall, input bit keep);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb[0];
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_seen", {63'd0, |req_ready}, 1);
    if (req_ready == '0) return;
    chk("accept_port", req_ready, onehot(e.port));
    @(posedge clk);
    #1;
    if (!keep) req_valid[e.port] = 1'b0;
    @(negedge clk);
    chk("issue_valid", mem_req_valid, 1);
    chk("issue_data", mem_req_flat, e.req);
    chk("issue_grant", grant_id, e.port);
    chk("issue_rsp_pulse", rsp_valid, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_data", mem_req_flat, e.req);
      chk("stall_no_ready", req_ready, 0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("wait_busy", busy, 1);
    chk("wait_no_mreq", mem_req_valid, 0);
    chk("wait_no_ready", req_ready, 0);
    mem_rsp_flat  = e.rsp;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rsp_port", rsp_valid, onehot(e.port));
    chk("rsp_data", rsp_flat, e.rsp);
    chk("rsp_idle", busy, 0);
    last_rsp = e.rsp;
    void'(sb.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_flat      = '0;
    req_valid     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_flat  = '0;
    mem_rsp_valid = 1'b0;
    last_rsp      = '0;
    do_reset();

    // Single request from port 2.
    @(negedge clk);
    set_req(2, 64'hA5);
    push(2, 64'hA5, 32'h1234);
    run_one(0, 1'b0);
    @(negedge clk);
    chk("pulse_one_cycle", rsp_valid, 0);
    chk("rsp_hold", rsp_flat, 32'h1234);

    // Fairness after grant 2: port 3 ahead of port 1.
    set_req(1, 64'h1111_0001);
    set_req(3, 64'h3333_0003);
    push(3, 64'h3333_0003, rsp_of(64'h3333_0003));
    push(1, 64'h1111_0001, rsp_of(64'h1111_0001));
    run_one(0, 1'b0);
    run_one(0, 1'b0);

    // Backpressure on port 0 while port 1 waits its turn.
    @(negedge clk);
    set_req(0, 64'hBEEF_0000_0000_00B0);
    set_req(1, 64'h1111_0002);
    push(0, 64'hBEEF_0000_0000_00B0, rsp_of(64'hBEEF_0000_0000_00B0));
    push(1, 64'h1111_0002, rsp_of(64'h1111_0002));
    run_one(5, 1'b0);
    run_one(2, 1'b0);

    // Stray memory response while idle.
    @(negedge clk);
    mem_rsp_flat  = 32'hDEAD_BEEF;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stray_err", perr, 1);
    chk("stray_no_rsp", rsp_valid, 0);
    chk("stray_data_kept", rsp_flat, last_rsp);
    repeat (3) @(negedge clk);
    chk("stray_err_sticky", perr, 1);

    // All ports valid continuously from reset.
    do_reset();
    for (int k = 0; k < NP; k++) set_req(k, 64'h1000 + 64'(k));
    for (int k = 0; k < 5; k++) begin
      push(k % NP, 64'h1000 + 64'(k % NP),
           rsp_of(64'h1000 + 64'(k % NP)));
    end
    for (int k = 0; k < 5; k++) run_one(k % 2, 1'b1);
    req_valid = '0;

    // Reset asserted while waiting on memory.
    do_reset();
    set_req(1, 64'h77);
    #1;
    chk("mid_accept", req_ready, onehot(1));
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mid_wait_busy", busy, 1);
    set_req(0, 64'h0A0A);
    set_req(2, 64'h2A2A);
    reset = 1'b1;
    #1;
    check_idle_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    mem_rsp_flat  = 32'h0BAD_0BAD;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late_no_rsp", rsp_valid, 0);
    chk("late_err", perr, 1);
    set_req(0, 64'h0A0A);
    set_req(2, 64'h2A2A);
    push(0, 64'h0A0A, rsp_of(64'h0A0A));
    push(2, 64'h2A2A, rsp_of(64'h2A2A));
    run_one(0, 1'b0);
    run_one(1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
